// File: rtl/silver_pkg.sv
// Shared types, bit positions and routing helpers for the silver-flit allocator.
package silver_pkg;

  localparam int unsigned FLIT_W   = 11;
  localparam int unsigned VALID_B  = 10;
  localparam int unsigned SILVER_B = 9;
  localparam int unsigned DX_HI    = 5;
  localparam int unsigned DX_LO    = 3;
  localparam int unsigned DY_HI    = 2;
  localparam int unsigned DY_LO    = 0;
  localparam int unsigned COORD_W  = 3;
  localparam int unsigned DEST_W   = 6;
  localparam int unsigned NPORT    = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {P_N, P_S, P_E, P_W} port_e;

  // Fallback scan order when a flit's productive port is taken.
  localparam port_e DEFL_ORDER [NPORT] = '{P_N, P_E, P_S, P_W};

  // X first, then Y; a local destination falls through to P_S and is flagged separately.
  function automatic port_e productive_port(input logic [DEST_W-1:0]  dest,
                                            input logic [COORD_W-1:0] lx,
                                            input logic [COORD_W-1:0] ly);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    port_e p;
    dx = dest[DX_HI:DX_LO];
    dy = dest[DY_HI:DY_LO];
    p  = P_S;
    if (dx > lx)      p = P_E;
    else if (dx < lx) p = P_W;
    else if (dy > ly) p = P_N;
    return p;
  endfunction

  function automatic flit_t strip_silver(input flit_t f);
    flit_t r;
    r           = f;
    r[SILVER_B] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/silver_alloc_if.sv
// Port bundle between the router datapath / local sink and the silver allocator.
interface silver_alloc_if
  import silver_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  flit_t            northad;
  flit_t            southad;
  flit_t            eastad;
  flit_t            westad;
  flit_t            nad;
  flit_t            sad;
  flit_t            ead;
  flit_t            wad;
  flit_t            ej_flit;
  logic             ej_valid;
  logic             ej_ready;
  logic             silver_err;
  logic [CNT_W-1:0] silver_eject_cnt;
  logic [CNT_W-1:0] deflect_cnt;

  modport master (
    output northad, southad, eastad, westad, ej_ready,
    input  nad, sad, ead, wad, ej_flit, ej_valid, silver_err, silver_eject_cnt, deflect_cnt
  );

  modport slave (
    input  northad, southad, eastad, westad, ej_ready,
    output nad, sad, ead, wad, ej_flit, ej_valid, silver_err, silver_eject_cnt, deflect_cnt
  );
endinterface

// File: rtl/silver_route_calc.sv
// Combinational productive-port lookup for one input flit.
module silver_route_calc
  import silver_pkg::*;
#(
  parameter logic [COORD_W-1:0] LOCAL_X = 3'd2,
  parameter logic [COORD_W-1:0] LOCAL_Y = 3'd2
) (
  input  logic [DEST_W-1:0] dest_i,
  output port_e             port_o,
  output logic              local_o
);
  assign port_o  = productive_port(dest_i, LOCAL_X, LOCAL_Y);
  assign local_o = (dest_i == {LOCAL_X, LOCAL_Y});
endmodule

// File: rtl/silver_alloc.sv
// Ejection and output-port allocation with silver-flit priority; all outputs registered.
module silver_alloc
  import silver_pkg::*;
#(
  parameter logic [COORD_W-1:0] LOCAL_X = 3'd2,
  parameter logic [COORD_W-1:0] LOCAL_Y = 3'd2,
  parameter int unsigned        CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  silver_alloc_if.slave bus
);

  flit_t             in_f [NPORT];
  logic [NPORT-1:0]  vld;
  logic [NPORT-1:0]  slv;
  logic [NPORT-1:0]  loc;
  port_e             prod [NPORT];

  flit_t             port_q [NPORT];
  flit_t             port_d [NPORT];
  flit_t             ej_flit_q;
  logic              ej_valid_q;
  logic              silver_err_q;
  logic [CNT_W-1:0]  silver_cnt_q;
  logic [CNT_W-1:0]  defl_cnt_q;

  logic              has_slv;
  logic              multi_slv;
  logic [1:0]        sidx;
  logic              cand_ok;
  logic [1:0]        cidx;
  logic              slot_free;
  logic              do_eject;
  logic [NPORT-1:0]  busy;
  logic [2:0]        defl;
  logic              take;
  logic              placed;
  logic [1:0]        idx;
  logic [CNT_W:0]    defl_sum;

  assign in_f[0] = bus.northad;
  assign in_f[1] = bus.southad;
  assign in_f[2] = bus.eastad;
  assign in_f[3] = bus.westad;

  for (genvar g = 0; g < NPORT; g++) begin : g_route
    assign vld[g] = in_f[g][VALID_B];
    assign slv[g] = vld[g] & in_f[g][SILVER_B];
    silver_route_calc #(.LOCAL_X(LOCAL_X), .LOCAL_Y(LOCAL_Y)) u_route (
      .dest_i (in_f[g][DX_HI:DY_LO]),
      .port_o (prod[g]),
      .local_o(loc[g])
    );
  end

  always_comb begin
    has_slv   = 1'b0;
    multi_slv = 1'b0;
    sidx      = 2'd0;
    cand_ok   = 1'b0;
    cidx      = 2'd0;
    busy      = '0;
    defl      = 3'd0;
    take      = 1'b0;
    placed    = 1'b0;
    idx       = 2'd0;
    for (int i = 0; i < NPORT; i++) port_d[i] = '0;

    for (int i = 0; i < NPORT; i++) begin
      if (slv[i]) begin
        if (has_slv) multi_slv = 1'b1;
        else begin
          has_slv = 1'b1;
          sidx    = 2'(i);
        end
      end
    end

    // Silver gets first claim on the ejection slot, then N,S,E,W.
    if (has_slv && loc[sidx]) begin
      cand_ok = 1'b1;
      cidx    = sidx;
    end else begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (vld[i] && loc[i]) begin
          cand_ok = 1'b1;
          cidx    = 2'(i);
        end
      end
    end
    slot_free = !ej_valid_q || bus.ej_ready;
    do_eject  = cand_ok && slot_free;

    // Pass 0 serves the silver flit; passes 1..4 serve the remaining inputs in order.
    for (int k = 0; k <= NPORT; k++) begin
      if (k == 0) begin
        idx  = sidx;
        take = has_slv;
      end else begin
        idx  = 2'(k - 1);
        take = !(has_slv && (sidx == idx));
      end
      if (take && vld[idx] && !(do_eject && (cidx == idx))) begin
        placed = 1'b0;
        if (!loc[idx] && !busy[prod[idx]]) begin
          port_d[prod[idx]] = strip_silver(in_f[idx]);
          busy[prod[idx]]   = 1'b1;
          placed            = 1'b1;
        end
        for (int j = 0; j < NPORT; j++) begin
          if (!placed && !busy[DEFL_ORDER[j]]) begin
            port_d[DEFL_ORDER[j]] = strip_silver(in_f[idx]);
            busy[DEFL_ORDER[j]]   = 1'b1;
            placed                = 1'b1;
            defl                  = defl + 3'd1;
          end
        end
      end
    end

    defl_sum = {1'b0, defl_cnt_q} + (CNT_W+1)'(defl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) port_q[i] <= '0;
      ej_flit_q    <= '0;
      ej_valid_q   <= 1'b0;
      silver_err_q <= 1'b0;
      silver_cnt_q <= '0;
      defl_cnt_q   <= '0;
    end else begin
      port_q <= port_d;
      if (multi_slv) silver_err_q <= 1'b1;
      defl_cnt_q <= defl_sum[CNT_W] ? '1 : defl_sum[CNT_W-1:0];
      if (do_eject) begin
        ej_flit_q  <= strip_silver(in_f[cidx]);
        ej_valid_q <= 1'b1;
        if (has_slv && (cidx == sidx) && (silver_cnt_q != '1))
          silver_cnt_q <= silver_cnt_q + CNT_W'(1);
      end else if (ej_valid_q && bus.ej_ready) begin
        ej_valid_q <= 1'b0;
      end
    end
  end

  assign bus.nad              = port_q[P_N];
  assign bus.sad              = port_q[P_S];
  assign bus.ead              = port_q[P_E];
  assign bus.wad              = port_q[P_W];
  assign bus.ej_flit          = ej_flit_q;
  assign bus.ej_valid         = ej_valid_q;
  assign bus.silver_err       = silver_err_q;
  assign bus.silver_eject_cnt = silver_cnt_q;
  assign bus.deflect_cnt      = defl_cnt_q;

endmodule

// File: tb/tb_silver_alloc.sv
// Directed plus randomized bench for silver_alloc against a queue-based reference model.
module tb_silver_alloc;
  localparam int unsigned CNT_W = 16;
  localparam int          CMAX  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic [10:0] in_v [4] = '{default: 11'h0};

  always #5 clk = ~clk;

  silver_alloc_if #(.CNT_W(CNT_W)) bus ();

  assign bus.northad  = in_v[0];
  assign bus.southad  = in_v[1];
  assign bus.eastad   = in_v[2];
  assign bus.westad   = in_v[3];
  assign bus.ej_ready = rdy;

  silver_alloc #(.LOCAL_X(3'd2), .LOCAL_Y(3'd2), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Expected state: ports indexed 0=N,1=S,2=E,3=W.
  logic [10:0] m_port [4] = '{default: 11'h0};
  logic [10:0] m_ejf = 11'h0;
  bit          m_ejv = 0;
  bit          m_err = 0;
  int          m_scnt = 0;
  int          m_dcnt = 0;

  function automatic bit is_local(input logic [10:0] f);
    return (f[5:3] == 3'd2) && (f[2:0] == 3'd2);
  endfunction

  function automatic int prod_dir(input logic [10:0] f);
    int x = int'(f[5:3]);
    int y = int'(f[2:0]);
    if (x > 2) return 2;
    if (x < 2) return 3;
    if (y > 2) return 0;
    return 1;
  endfunction

  function automatic logic [10:0] rnd_flit();
    logic [10:0] f;
    f[10]  = ($urandom_range(0, 9) < 7);
    f[9]   = ($urandom_range(0, 3) == 0);
    f[8:6] = 3'($urandom);
    f[5:3] = 3'($urandom_range(1, 3));
    f[2:0] = 3'($urandom_range(1, 3));
    return f;
  endfunction

  task automatic model_next();
    int order[$];
    int freep[$];
    int sil = -1;
    int ns = 0;
    int ej = -1;
    int d = 0;
    bit slot_free;
    logic [10:0] np [4];
    if (rst) begin
      m_port = '{default: 11'h0};
      m_ejf = 11'h0; m_ejv = 0; m_err = 0; m_scnt = 0; m_dcnt = 0;
      return;
    end
    for (int i = 0; i < 4; i++)
      if (in_v[i][10] && in_v[i][9]) begin
        ns++;
        if (sil < 0) sil = i;
      end
    if (ns > 1) m_err = 1;
    if (sil >= 0) order.push_back(sil);
    for (int i = 0; i < 4; i++)
      if (in_v[i][10] && i != sil) order.push_back(i);
    slot_free = !m_ejv || rdy;
    foreach (order[k]) if (ej < 0 && is_local(in_v[order[k]])) ej = order[k];
    if (m_ejv && rdy) m_ejv = 0;
    if (ej >= 0 && slot_free) begin
      m_ejf = in_v[ej] & 11'h5FF;
      m_ejv = 1;
      if (ej == sil) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else ej = -1;
    freep = '{0, 2, 1, 3};
    np = '{default: 11'h0};
    foreach (order[k]) begin
      int f = order[k];
      int p = -1;
      if (f == ej) continue;
      if (!is_local(in_v[f]))
        for (int q = 0; q < freep.size(); q++)
          if (freep[q] == prod_dir(in_v[f])) begin
            p = freep[q];
            freep.delete(q);
            break;
          end
      if (p < 0) begin
        p = freep.pop_front();
        d++;
      end
      np[p] = in_v[f] & 11'h5FF;
    end
    m_port = np;
    m_dcnt = (m_dcnt + d > CMAX) ? CMAX : m_dcnt + d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check("nad", 32'(bus.nad), 32'(m_port[0]));
    check("sad", 32'(bus.sad), 32'(m_port[1]));
    check("ead", 32'(bus.ead), 32'(m_port[2]));
    check("wad", 32'(bus.wad), 32'(m_port[3]));
    check("ej_valid", 32'(bus.ej_valid), 32'(m_ejv));
    if (m_ejv) check("ej_flit", 32'(bus.ej_flit), 32'(m_ejf));
    check("silver_err", 32'(bus.silver_err), 32'(m_err));
    check("silver_eject_cnt", 32'(bus.silver_eject_cnt), 32'(m_scnt));
    check("deflect_cnt", 32'(bus.deflect_cnt), 32'(m_dcnt));
  endtask

  task automatic idle();
    in_v = '{default: 11'h0};
  endtask

  initial begin
    // Reset with random inputs, then release with idle inputs.
    rst = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) in_v[i] = rnd_flit();
    step();
    for (int i = 0; i < 4; i++) in_v[i] = rnd_flit();
    step();
    rst = 1'b0; idle();
    step();
    check("rst_ej_flit", 32'(bus.ej_flit), 32'h0);
    check("rst_cnt", 32'(bus.deflect_cnt), 32'h0);

    // Silver flit destined here ejects with bit 9 cleared.
    in_v[0] = 11'h612; rdy = 1'b1;
    step();
    check("silver_ej_flit", 32'(bus.ej_flit), 32'h412);
    check("silver_ej_valid", 32'(bus.ej_valid), 32'h1);
    check("silver_ej_cnt", 32'(bus.silver_eject_cnt), 32'h1);

    // Silver east and normal north both want E.
    idle(); in_v[0] = 11'h41A; in_v[2] = 11'h61A;
    step();
    check("cont_ead", 32'(bus.ead), 32'h41A);
    check("cont_nad", 32'(bus.nad), 32'h41A);
    check("cont_defl", 32'(bus.deflect_cnt), 32'h1);

    // Back-pressure: fill slot, stall, then drain.
    idle(); in_v[0] = 11'h4D2; rdy = 1'b0;
    step();
    idle(); in_v[1] = 11'h412;
    step();
    check("bp_ej_flit", 32'(bus.ej_flit), 32'h4D2);
    check("bp_nad", 32'(bus.nad), 32'h412);
    check("bp_defl", 32'(bus.deflect_cnt), 32'h2);
    idle(); rdy = 1'b1;
    step();
    check("bp_drain", 32'(bus.ej_valid), 32'h0);

    // Two silver flits: north wins, error is sticky.
    in_v[0] = 11'h61A; in_v[3] = 11'h60A;
    step();
    check("dbl_err", 32'(bus.silver_err), 32'h1);
    check("dbl_ead", 32'(bus.ead), 32'h41A);
    check("dbl_wad", 32'(bus.wad), 32'h40A);
    idle();
    step();
    step();
    check("dbl_sticky", 32'(bus.silver_err), 32'h1);

    // Four flits to E: three deflections, then load the ejection slot.
    in_v = '{default: 11'h41A};
    step();
    idle(); in_v[0] = 11'h412;
    step();
    check("pre_rst_defl", 32'(bus.deflect_cnt), 32'h5);
    check("pre_rst_ejv", 32'(bus.ej_valid), 32'h1);

    // Mid-stream reset with valid traffic.
    rst = 1'b1; in_v = '{11'h612, 11'h41A, 11'h40A, 11'h413};
    step();
    check("mid_rst_ejv", 32'(bus.ej_valid), 32'h0);
    check("mid_rst_defl", 32'(bus.deflect_cnt), 32'h0);
    check("mid_rst_err", 32'(bus.silver_err), 32'h0);
    rst = 1'b0;

    // Randomized traffic, ready and occasional reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) in_v[i] = rnd_flit();
      rdy = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
